// File: rtl/varredura_linhas.sv
// Row-scan sequencer for the LED dot-matrix icon display.
// Produces the row selector S, the active-low one-hot row enables with a
// blanking gap at the start of each row slot, a frame-start pulse and the
// slow image-alternation phase Fase. Every output is a flop.
module varredura_linhas #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned BLANK  = 1,
  parameter int unsigned ROWS   = 7,
  parameter int unsigned FRAMES = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  output logic [2:0]      S,
  output logic [ROWS-1:0] Linhas,
  output logic            Blank,
  output logic            FrameStart,
  output logic            Fase
);

  localparam int unsigned PW = (DIV > 1)    ? $clog2(DIV)    : 1;
  localparam int unsigned RW = (ROWS > 1)   ? $clog2(ROWS)   : 1;
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  logic [PW-1:0]   r_presc;
  logic [RW-1:0]   r_row;
  logic [FW-1:0]   r_frame;
  logic            r_fase;
  logic [ROWS-1:0] r_linhas;
  logic            r_blank;
  logic            r_frame_start;

  logic [PW-1:0]   w_presc_nxt;
  logic [RW-1:0]   w_row_nxt;
  logic [FW-1:0]   w_frame_nxt;
  logic            w_fase_nxt;
  logic [ROWS-1:0] w_linhas_nxt;
  logic            w_lit;
  logic            w_wrap;
  logic            w_presc_last;
  logic            w_row_last;
  logic            w_frame_last;

  // Next-state of the cascaded prescaler/row/frame counters and the output
  // values that will describe that next state.
  always_comb begin
    w_presc_nxt  = r_presc;
    w_row_nxt    = r_row;
    w_frame_nxt  = r_frame;
    w_fase_nxt   = r_fase;
    w_linhas_nxt = '1;
    w_lit        = 1'b0;
    w_wrap       = 1'b0;

    w_presc_last = (r_presc == PW'(DIV - 1));
    w_row_last   = (r_row   == RW'(ROWS - 1));
    w_frame_last = (r_frame == FW'(FRAMES - 1));

    if (Enable) begin
      w_presc_nxt = w_presc_last ? '0 : r_presc + PW'(1);
      if (w_presc_last) begin
        w_row_nxt = w_row_last ? '0 : r_row + RW'(1);
        if (w_row_last) begin
          w_wrap      = 1'b1;
          w_frame_nxt = w_frame_last ? '0 : r_frame + FW'(1);
          if (w_frame_last) begin
            w_fase_nxt = ~r_fase;
          end
        end
      end
      // Row lights only after the blank window so column data has settled.
      w_lit = (w_presc_nxt >= PW'(BLANK));
    end

    if (w_lit) begin
      w_linhas_nxt[w_row_nxt] = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_presc       <= '0;
      r_row         <= '0;
      r_frame       <= '0;
      r_fase        <= 1'b0;
      r_linhas      <= '1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_presc       <= w_presc_nxt;
      r_row         <= w_row_nxt;
      r_frame       <= w_frame_nxt;
      r_fase        <= w_fase_nxt;
      r_linhas      <= w_linhas_nxt;
      r_blank       <= ~w_lit;
      r_frame_start <= w_wrap;
    end
  end

  assign S          = 3'(r_row);
  assign Linhas     = r_linhas;
  assign Blank      = r_blank;
  assign FrameStart = r_frame_start;
  assign Fase       = r_fase;

endmodule
